sync_pulse_gen: RTL and testbench

- Transmit side of the sync/1 Hz timing interface.
- Generates three periodic sync strobes (sync0, sync1, sync2) and a local second mark (pps_out) in the clk125 domain.
- Outputs are phase-aligned to an external 1 Hz mark (pps_in) when that mark is valid; the block free-runs in holdover when it is missing or out of tolerance.
- Outputs drive the board sync lines that the 48 MHz period monitor measures.

---
 rtl/sync_pulse_gen.sv | 178 +++++++++++++++++
 tb/tb_sync_pulse_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_gen.sv
// Sync-strobe and 1 Hz mark generator, phase-locked to an external pps_in mark with holdover.
// Optional macro SYNC_PPS_PERIOD_EN adds capture of the accepted pps_in interval on pps_period.
module sync_pulse_gen #(
  parameter int unsigned FREQ_CLK = 125_000_000,
  parameter int unsigned DELTA    = 5000,
  parameter int unsigned PPS_W    = 16,
  parameter int unsigned P0_DEF   = 125_000,
  parameter int unsigned P1_DEF   = 1_250_000,
  parameter int unsigned P2_DEF   = 125_000_000,
  parameter int unsigned W_DEF    = 8
) (
  input  logic        clk125,
  input  logic        rst,
  input  logic        en,
  input  logic        pps_in,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  output logic        sync0,
  output logic        sync1,
  output logic        sync2,
  output logic        pps_out,
  output logic        locked,
  output logic [1:0]  state,
  output logic [15:0] pps_err,
  output logic [31:0] pps_period
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [31:0] GAP_LO   = 32'(FREQ_CLK - DELTA);
  localparam logic [31:0] GAP_HI   = 32'(FREQ_CLK + DELTA);
  localparam logic [31:0] SEC_LAST = 32'(FREQ_CLK - 1);
  localparam logic [31:0] PPS_WL   = 32'(PPS_W);

  state_t      st, st_nx;
  logic        pps_p0, pps_p1, pps_p2;
  logic        edge_det, in_win, timeout, accept, reject;
  logic        realign, running, wrap, boundary;
  logic [31:0] gap;
  logic [31:0] sec_cnt;
  logic [31:0] ch_cnt  [3];
  logic [31:0] per_sh  [3];
  logic [31:0] per_act [3];
  logic [15:0] wid_sh, wid_act;
  logic        sync_q  [3];

  assign state    = st;
  assign edge_det = pps_p1 & ~pps_p2;
  assign in_win   = (gap >= GAP_LO) && (gap <= GAP_HI);
  assign timeout  = gap > GAP_HI;
  assign accept   = en && (st == RUN) && edge_det && in_win;
  assign reject   = en && (st == RUN) && edge_det && !in_win;
  assign running  = (st == RUN) || (st == HOLD);
  assign wrap     = running && (sec_cnt == SEC_LAST);
  // A realign coinciding with a wrap is still a single boundary.
  assign boundary = realign || wrap;

  assign sync0 = sync_q[0];
  assign sync1 = sync_q[1];
  assign sync2 = sync_q[2];

  always_comb begin
    st_nx   = st;
    realign = 1'b0;
    case (st)
      IDLE: if (en) st_nx = ARM;
      ARM: begin
        if (edge_det) begin
          st_nx   = RUN;
          realign = 1'b1;
        end else if (timeout) begin
          st_nx   = HOLD;
          realign = 1'b1;
        end
      end
      RUN: begin
        realign = accept;
        if (timeout) st_nx = HOLD;
      end
      HOLD: begin
        if (edge_det) begin
          st_nx   = RUN;
          realign = 1'b1;
        end
      end
      default: st_nx = IDLE;
    endcase
    if (!en) begin
      st_nx   = IDLE;
      realign = 1'b0;
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      st      <= IDLE;
      locked  <= 1'b0;
      pps_p0  <= 1'b0;
      pps_p1  <= 1'b0;
      pps_p2  <= 1'b0;
      gap     <= '0;
      pps_err <= '0;
      sec_cnt <= '0;
      pps_out <= 1'b0;
      per_sh[0]  <= 32'(P0_DEF);
      per_sh[1]  <= 32'(P1_DEF);
      per_sh[2]  <= 32'(P2_DEF);
      per_act[0] <= 32'(P0_DEF);
      per_act[1] <= 32'(P1_DEF);
      per_act[2] <= 32'(P2_DEF);
      wid_sh  <= 16'(W_DEF);
      wid_act <= 16'(W_DEF);
      for (int n = 0; n < 3; n++) begin
        ch_cnt[n] <= '0;
        sync_q[n] <= 1'b0;
      end
    end else begin
      st     <= st_nx;
      locked <= (st_nx == RUN);
      // pps_in synchronizer stages
      pps_p0 <= pps_in;
      pps_p1 <= pps_p0;
      pps_p2 <= pps_p1;

      if ((st == IDLE) || edge_det) gap <= '0;
      else if (gap != '1)           gap <= gap + 32'd1;

      if (reject && (pps_err != '1)) pps_err <= pps_err + 16'd1;

      if (cfg_we) begin
        case (cfg_sel)
          2'd0:    per_sh[0] <= cfg_data;
          2'd1:    per_sh[1] <= cfg_data;
          2'd2:    per_sh[2] <= cfg_data;
          default: wid_sh    <= cfg_data[15:0];
        endcase
      end
      if (boundary) begin
        per_act <= per_sh;
        wid_act <= wid_sh;
      end

      // Channels restart on every second boundary so a new period starts cleanly.
      if (!running || boundary) begin
        sec_cnt <= '0;
        for (int n = 0; n < 3; n++) ch_cnt[n] <= '0;
      end else begin
        sec_cnt <= sec_cnt + 32'd1;
        for (int n = 0; n < 3; n++) begin
          if (ch_cnt[n] + 32'd1 >= per_act[n]) ch_cnt[n] <= '0;
          else                                 ch_cnt[n] <= ch_cnt[n] + 32'd1;
        end
      end

      // Output register stage
      pps_out <= running && (sec_cnt < PPS_WL);
      for (int n = 0; n < 3; n++) begin
        sync_q[n] <= running && (per_act[n] > {16'd0, wid_act}) &&
                     (ch_cnt[n] < {16'd0, wid_act});
      end
    end
  end

`ifdef SYNC_PPS_PERIOD_EN
  logic [31:0] period_q;

  always_ff @(posedge clk125) begin
    if (rst)         period_q <= '0;
    else if (accept) period_q <= gap + 32'd1;
  end

  assign pps_period = period_q;
`else
  assign pps_period = '0;
`endif

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Directed bench for sync_pulse_gen at a scaled-down 1000-cycle second.
module tb_sync_pulse_gen;

  logic        clk125 = 1'b0;
  logic        rst, en, pps_in, cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        sync0, sync1, sync2, pps_out, locked;
  logic [1:0]  state;
  logic [15:0] pps_err;
  logic [31:0] pps_period;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, t1, t2, t3, t5, t6, t7;
  logic [31:0] exp_period;

  sync_pulse_gen #(
    .FREQ_CLK(1000), .DELTA(10), .PPS_W(4),
    .P0_DEF(100), .P1_DEF(250), .P2_DEF(1000), .W_DEF(4)
  ) dut (
    .clk125(clk125), .rst(rst), .en(en), .pps_in(pps_in),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .sync0(sync0), .sync1(sync1), .sync2(sync2), .pps_out(pps_out),
    .locked(locked), .state(state), .pps_err(pps_err), .pps_period(pps_period)
  );

  always #4 clk125 = ~clk125;
  always @(posedge clk125) cyc <= cyc + 1;

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk125);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pps_in = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 32'd0;
`ifdef SYNC_PPS_PERIOD_EN
    exp_period = 32'd1003;
`else
    exp_period = 32'd0;
`endif

    // Reset state
    at(3);
    check("rst_outs", {27'd0, sync0, sync1, sync2, pps_out, locked}, 32'd0);
    check("rst_state", state, 32'd0);
    check("rst_err", pps_err, 32'd0);
    check("rst_period", pps_period, 32'd0);
    rst = 1'b0;
    at(5);
    check("idle_no_en", state, 32'd0);
    en = 1'b1;
    at(6);
    check("arm", state, 32'd1);

    // Lock on first edge, 4-cycle latency
    at(10); t0 = cyc; pps_in = 1'b1;
    at(t0 + 3);
    check("lock_state", state, 32'd2);
    check("lock_locked", locked, 32'd1);
    check("lock_pre_sync0", sync0, 32'd0);
    at(t0 + 4);
    check("lock_rise_all", {28'd0, sync0, sync1, sync2, pps_out}, 32'hf);
    at(t0 + 10); pps_in = 1'b0;
    at(t0 + 103); check("s0_pre_rise", sync0, 32'd0);
    at(t0 + 104); check("s0_rise_100", sync0, 32'd1);
    check("s1_low_100", sync1, 32'd0);
    at(t0 + 108); check("s0_width4", sync0, 32'd0);
    at(t0 + 254); check("s1_rise_250", sync1, 32'd1);

    // Second edge at 1000
    at(t0 + 1000); t1 = cyc; pps_in = 1'b1;
    at(t1 + 3); check("e2_pre_sync0", sync0, 32'd0);
    at(t1 + 4);
    check("e2_rise_all", {28'd0, sync0, sync1, sync2, pps_out}, 32'hf);
    check("e2_err", pps_err, 32'd0);
    at(t1 + 10); pps_in = 1'b0;

    // Tolerance: 995 accepted, 1012 rejected and timeout to HOLD
    at(t1 + 995); t2 = cyc; pps_in = 1'b1;
    at(t2 + 4);
    check("tol995_realign_s0", sync0, 32'd1);
    check("tol995_realign_pps", pps_out, 32'd1);
    at(t2 + 10); pps_in = 1'b0;
    at(t2 + 1012); pps_in = 1'b1;
    at(t2 + 1014);
    check("tol_pre_state", state, 32'd2);
    check("tol_pre_err", pps_err, 32'd0);
    at(t2 + 1015);
    check("hold_state", state, 32'd3);
    check("hold_locked", locked, 32'd0);
    check("rej_err", pps_err, 32'd1);
    at(t2 + 1016); check("rej_no_realign", sync0, 32'd0);
    at(t2 + 1022); pps_in = 1'b0;
    at(t2 + 1103); check("hold_pre_rise", sync0, 32'd0);
    at(t2 + 1104); check("hold_no_jump", sync0, 32'd1);

    // Holdover recovery at arbitrary phase
    at(t2 + 1150); t3 = cyc; pps_in = 1'b1;
    at(t3 + 3);
    check("rec_state", state, 32'd2);
    check("rec_locked", locked, 32'd1);
    check("rec_pre_sync0", sync0, 32'd0);
    at(t3 + 4);
    check("rec_sync0", sync0, 32'd1);
    check("rec_pps", pps_out, 32'd1);
    at(t3 + 10); pps_in = 1'b0;

    // Config: period 50 deferred to next boundary
    at(t3 + 500); cfg_sel = 2'd0; cfg_data = 32'd50; cfg_we = 1'b1;
    at(t3 + 501); cfg_we = 1'b0;
    at(t3 + 604); check("cfg_old_p_rise", sync0, 32'd1);
    at(t3 + 654); check("cfg_old_p_low", sync0, 32'd0);
    at(t3 + 1004); check("cfg_bnd_rise", sync0, 32'd1);
    at(t3 + 1054); check("cfg_new_p50", sync0, 32'd1);
    at(t3 + 1100); cfg_sel = 2'd3; cfg_data = 32'd60; cfg_we = 1'b1;
    at(t3 + 1101); cfg_we = 1'b0;
    at(t3 + 1904); check("cfg_w_pending", sync0, 32'd1);
    at(t3 + 2004);
    check("cfg_w60_forced", sync0, 32'd0);
    check("cfg_w60_s1", sync1, 32'd1);
    check("cfg_w60_s2", sync2, 32'd1);
    at(t3 + 2030); check("cfg_w60_forced2", sync0, 32'd0);
    at(t3 + 2060); check("cfg_w60_s1_wide", sync1, 32'd1);

    // Disable while sync2 high
    en = 1'b0;
    at(t3 + 2061);
    check("dis_state", state, 32'd0);
    check("dis_s2_still", sync2, 32'd1);
    at(t3 + 2062);
    check("dis_outs_low", {27'd0, sync0, sync1, sync2, pps_out, locked}, 32'd0);

    // Re-enable, lock, then reset mid-pulse
    at(t3 + 2070); en = 1'b1;
    at(t3 + 2071); check("reen_arm", state, 32'd1);
    at(t3 + 2080); t5 = cyc; pps_in = 1'b1;
    at(t5 + 4);
    check("reen_s1", sync1, 32'd1);
    check("reen_s0_forced", sync0, 32'd0);
    at(t5 + 10); pps_in = 1'b0; rst = 1'b1;
    at(t5 + 11);
    check("rstmid_outs", {27'd0, sync0, sync1, sync2, pps_out, locked}, 32'd0);
    check("rstmid_state", state, 32'd0);
    at(t5 + 12); rst = 1'b0;
    at(t5 + 13); check("postrst_arm", state, 32'd1);
    at(t5 + 20); t6 = cyc; pps_in = 1'b1;
    at(t6 + 4);
    check("def_s0_rise", sync0, 32'd1);
    check("def_period_zero", pps_period, 32'd0);
    at(t6 + 8); check("def_w4", sync0, 32'd0);
    at(t6 + 10); pps_in = 1'b0;
    at(t6 + 104); check("def_p100", sync0, 32'd1);
    at(t6 + 254); check("def_p250", sync1, 32'd1);
    at(t6 + 258); check("def_p250_w4", sync1, 32'd0);

    // Accepted 1003 interval
    at(t6 + 1003); t7 = cyc; pps_in = 1'b1;
    at(t7 + 3);
    check("per_state", state, 32'd2);
    check("per_capture", pps_period, exp_period);
    at(t7 + 4); check("per_realign", sync0, 32'd1);
    at(t7 + 10); pps_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
